// File: rtl/ecc_pkg.sv
// Shared definitions for the 32-bit double-error-correcting code: widths, generator masks,
// encoder FSM states and the single-bit polynomial-division step reused by the read-side syndrome logic.
package ecc_pkg;

    localparam int DATA_W = 32;
    localparam int CHKA_W = 7;
    localparam int CHKB_W = 8;
    localparam int STEP_W = 8;

    localparam logic [CHKA_W-1:0] GA_MASK = 7'h09;
    localparam logic [CHKB_W-1:0] GB_MASK = 8'h1D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } enc_state_t;

    // One MSB-first division step on a remainder of width w held right-aligned in STEP_W bits.
    function automatic logic [STEP_W-1:0] lfsr_step(
        input logic [STEP_W-1:0] rem,
        input logic              d,
        input logic [STEP_W-1:0] mask,
        input int                w
    );
        logic              fb;
        logic [STEP_W-1:0] nxt;
        fb  = d ^ rem[w-1];
        nxt = (rem << 1) ^ (fb ? mask : 8'h00);
        nxt = nxt & ((8'h01 << w) - 8'h01);
        return nxt;
    endfunction

    function automatic logic parity47(input logic [46:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/dec_lfsr_chunk.sv
// Combinational BPC-bit slice of serial polynomial division; data bits are consumed MSB first.
module dec_lfsr_chunk
    import ecc_pkg::*;
#(
    parameter int           W    = 7,
    parameter logic [W-1:0] MASK = 7'h09,
    parameter int           BPC  = 1
) (
    input  logic [W-1:0]   rem_in,
    input  logic [BPC-1:0] bits,
    output logic [W-1:0]   rem_out
);

    logic [STEP_W-1:0] acc_s;

    generate
        if (W > STEP_W || W < 1) begin : g_bad_width
            $error("dec_lfsr_chunk: W must be between 1 and 8");
        end
    endgenerate

    // Unrolled chain of BPC single-bit division steps
    always_comb begin
        acc_s = '0;
        acc_s[W-1:0] = rem_in;
        for (int i = BPC - 1; i >= 0; i--) begin
            acc_s = lfsr_step(acc_s, bits[i], STEP_W'(MASK), W);
        end
        rem_out = acc_s[W-1:0];
    end

endmodule

// File: rtl/dec_check_encoder.sv
// Write-side check-bit generator: chk_a/chk_b are the remainders of D(x)*x^k over gA/gB.
// Optional macro DEC_CHECK_ENCODER_PARITY_EN adds an overall parity output chk_p.
module dec_check_encoder
    import ecc_pkg::*;
#(
    parameter int BITS_PER_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [CHKA_W-1:0] chk_a,
    output logic [CHKB_W-1:0] chk_b
`ifdef DEC_CHECK_ENCODER_PARITY_EN
    ,
    output logic              chk_p
`endif
);

    localparam int N_CYC = DATA_W / BITS_PER_CYC;
    localparam int CNT_W = 6;

    generate
        if (BITS_PER_CYC != 1 && BITS_PER_CYC != 2 && BITS_PER_CYC != 4 &&
            BITS_PER_CYC != 8 && BITS_PER_CYC != 16 && BITS_PER_CYC != 32) begin : g_bad_bpc
            $error("dec_check_encoder: BITS_PER_CYC must be 1, 2, 4, 8, 16 or 32");
        end
    endgenerate

    enc_state_t          state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   sr_r;
    logic [CHKA_W-1:0]   rem_a_r;
    logic [CHKB_W-1:0]   rem_b_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   data_out_r;
    logic [CHKA_W-1:0]   chk_a_r;
    logic [CHKB_W-1:0]   chk_b_r;
    logic                chk_p_r;

    logic [CHKA_W-1:0]       rem_a_nxt_s;
    logic [CHKB_W-1:0]       rem_b_nxt_s;
    logic [BITS_PER_CYC-1:0] bits_s;
    logic                    last_s;

    assign bits_s = sr_r[DATA_W-1 -: BITS_PER_CYC];
    assign last_s = (cnt_r == CNT_W'(N_CYC - 1));

    dec_lfsr_chunk #(
        .W    (CHKA_W),
        .MASK (GA_MASK),
        .BPC  (BITS_PER_CYC)
    ) u_chunk_a (
        .rem_in  (rem_a_r),
        .bits    (bits_s),
        .rem_out (rem_a_nxt_s)
    );

    dec_lfsr_chunk #(
        .W    (CHKB_W),
        .MASK (GB_MASK),
        .BPC  (BITS_PER_CYC)
    ) u_chunk_b (
        .rem_in  (rem_b_r),
        .bits    (bits_s),
        .rem_out (rem_b_nxt_s)
    );

    // Handshake FSM, shift datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            sr_r        <= '0;
            rem_a_r     <= '0;
            rem_b_r     <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            data_out_r  <= '0;
            chk_a_r     <= '0;
            chk_b_r     <= '0;
            chk_p_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        sr_r       <= data_in;
                        data_out_r <= data_in;
                        rem_a_r    <= '0;
                        rem_b_r    <= '0;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_SHIFT;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    rem_a_r <= rem_a_nxt_s;
                    rem_b_r <= rem_b_nxt_s;
                    sr_r    <= sr_r << BITS_PER_CYC;
                    cnt_r   <= cnt_r + 6'd1;
                    if (last_s) begin
                        chk_a_r     <= rem_a_nxt_s;
                        chk_b_r     <= rem_b_nxt_s;
                        chk_p_r     <= parity47({data_out_r, rem_a_nxt_s, rem_b_nxt_s});
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Only the registered in_ready follows out_ready, so no combinational path exists
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;
    assign chk_a     = chk_a_r;
    assign chk_b     = chk_b_r;
`ifdef DEC_CHECK_ENCODER_PARITY_EN
    assign chk_p     = chk_p_r;
`else
    logic unused_p_s;
    assign unused_p_s = chk_p_r;
`endif

endmodule

// File: tb/tb_dec_check_encoder.sv
// Self-checking bench for dec_check_encoder at BITS_PER_CYC = 1, 4 and 32 against a long-division model.
module tb_dec_check_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] data_in   [3];
    logic [31:0] data_out  [3];
    logic [6:0]  chk_a     [3];
    logic [7:0]  chk_b     [3];
`ifdef DEC_CHECK_ENCODER_PARITY_EN
    logic        chk_p     [3];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dec_check_encoder #(
            .BITS_PER_CYC (g == 0 ? 1 : (g == 1 ? 4 : 32))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .data_in   (data_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .data_out  (data_out[g]),
            .chk_a     (chk_a[g]),
            .chk_b     (chk_b[g])
`ifdef DEC_CHECK_ENCODER_PARITY_EN
            ,
            .chk_p     (chk_p[g])
`endif
        );
    end

    // Remainder of D(x)*x^7 modulo x^7+x^3+1 by textbook long division
    function automatic logic [6:0] model_a(input logic [31:0] d);
        logic [38:0] v;
        v = {d, 7'b0};
        for (int i = 38; i >= 7; i--) begin
            if (v[i]) v = v ^ (39'h89 << (i - 7));
        end
        return v[6:0];
    endfunction

    // Remainder of D(x)*x^8 modulo x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] model_b(input logic [31:0] d);
        logic [39:0] v;
        v = {d, 8'b0};
        for (int i = 39; i >= 8; i--) begin
            if (v[i]) v = v ^ (40'h11D << (i - 8));
        end
        return v[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full transaction on one instance: handshake, wait for result, then release it
    task automatic encode(input int idx, input logic [31:0] d,
                          output logic [31:0] dout, output logic [6:0] a,
                          output logic [7:0] b, output logic p, output int lat);
        int guard;
        @(negedge clk);
        data_in[idx]  = d;
        in_valid[idx] = 1'b1;
        guard = 0;
        while (!in_ready[idx] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("accept_timeout", 32'(in_ready[idx]), 32'd1);
        @(posedge clk);
        #1 in_valid[idx] = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid[idx]) break;
        end
        dout = data_out[idx];
        a    = chk_a[idx];
        b    = chk_b[idx];
`ifdef DEC_CHECK_ENCODER_PARITY_EN
        p    = chk_p[idx];
`else
        p    = 1'b0;
`endif
        @(negedge clk);
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", 32'(out_valid[idx]), 32'd0);
        check("release_ready", 32'(in_ready[idx]), 32'd1);
        out_ready[idx] = 1'b0;
    endtask

    initial begin
        logic [31:0] dout, x, y, w;
        logic [6:0]  a, ax, ay;
        logic [7:0]  b, bx, by;
        logic        p;
        int          lat;
        logic        seen;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            data_in[i]   = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_out_valid", 32'(out_valid[i]), 32'd0);
            check("rst_in_ready", 32'(in_ready[i]), 32'd0);
            check("rst_chk_a", 32'(chk_a[i]), 32'd0);
            check("rst_chk_b", 32'(chk_b[i]), 32'd0);
            check("rst_data_out", data_out[i], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check("post_rst_ready", 32'(in_ready[i]), 32'd1);

        // Directed vectors at one bit per cycle
        encode(0, 32'h0000_0001, dout, a, b, p, lat);
        check("d1_lat", 32'(lat), 32'd32);
        check("d1_chk_a", 32'(a), 32'h09);
        check("d1_chk_b", 32'(b), 32'h1D);
        check("d1_dout", dout, 32'h0000_0001);
`ifdef DEC_CHECK_ENCODER_PARITY_EN
        check("d1_chk_p", 32'(p), 32'd1);
`endif
        encode(0, 32'h0000_0003, dout, a, b, p, lat);
        check("d3_chk_a", 32'(a), 32'h1B);
        check("d3_chk_b", 32'(b), 32'h27);
        encode(0, 32'h0000_0000, dout, a, b, p, lat);
        check("d0_chk_a", 32'(a), 32'h00);
        check("d0_chk_b", 32'(b), 32'h00);

        // Random words, linearity and double-error syndromes on every instance
        for (int idx = 0; idx < 3; idx++) begin
            for (int n = 0; n < 500; n++) begin
                w = $urandom;
                encode(idx, w, dout, a, b, p, lat);
                check("rnd_lat", 32'(lat), 32'(idx == 0 ? 32 : (idx == 1 ? 8 : 1)));
                check("rnd_chk_a", 32'(a), 32'(model_a(w)));
                check("rnd_chk_b", 32'(b), 32'(model_b(w)));
                check("rnd_dout", dout, w);
`ifdef DEC_CHECK_ENCODER_PARITY_EN
                check("rnd_chk_p", 32'(p), 32'(^w ^ ^model_a(w) ^ ^model_b(w)));
`endif
            end
            for (int n = 0; n < 10; n++) begin
                x = $urandom;
                y = $urandom;
                encode(idx, x, dout, ax, bx, p, lat);
                encode(idx, y, dout, ay, by, p, lat);
                encode(idx, x ^ y, dout, a, b, p, lat);
                check("lin_chk_a", 32'(a), 32'(ax ^ ay));
                check("lin_chk_b", 32'(b), 32'(bx ^ by));
            end
            w = $urandom;
            encode(idx, w, dout, ax, bx, p, lat);
            encode(idx, w ^ 32'h3, dout, a, b, p, lat);
            check("syn01_a", 32'(a ^ ax), 32'(model_a(32'h3)));
            check("syn01_b", 32'(b ^ bx), 32'(model_b(32'h3)));
            encode(idx, w ^ 32'h5, dout, a, b, p, lat);
            check("syn02_a", 32'(a ^ ax), 32'(model_a(32'h5)));
            check("syn02_b", 32'(b ^ bx), 32'(model_b(32'h5)));
        end

        // Back-pressure: hold out_ready low while in_valid pulses
        w = 32'hA5A5_0F0F;
        @(negedge clk);
        data_in[0]  = w;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        check("stall_valid_rise", 32'(out_valid[0]), 32'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid[0] = c[0];
            data_in[0]  = $urandom;
            @(posedge clk);
            #1;
            check("stall_valid", 32'(out_valid[0]), 32'd1);
            check("stall_ready", 32'(in_ready[0]), 32'd0);
            check("stall_chk_a", 32'(chk_a[0]), 32'(model_a(w)));
            check("stall_chk_b", 32'(chk_b[0]), 32'(model_b(w)));
            check("stall_dout", data_out[0], w);
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_valid", 32'(out_valid[0]), 32'd0);
        check("stall_release_ready", 32'(in_ready[0]), 32'd1);
        out_ready[0] = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen = seen | out_valid[0];
        end
        check("stall_no_extra_word", 32'(seen), 32'd0);

        // Reset in the middle of SHIFT abandons the word
        @(negedge clk);
        data_in[0]  = 32'hDEAD_BEEF;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid", 32'(out_valid[0]), 32'd0);
        check("midrst_chk_a", 32'(chk_a[0]), 32'd0);
        check("midrst_chk_b", 32'(chk_b[0]), 32'd0);
        check("midrst_dout", data_out[0], 32'd0);
        check("midrst_ready", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready_after", 32'(in_ready[0]), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen = seen | out_valid[0];
        end
        check("midrst_no_output", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
